if_pc_sequencer: RTL and testbench

- Fetch-stage PC sequencer that drives the instruction-delay phase counter and the current PC (IF_pcs) consumed by add_pc.
- Takes back add_pc's registered IF_pc4.
- On the commit phase of each instruction slot, selects the next PC from three sources: sequential (IF_pc4), taken conditional branch (IF_pcs + imm), or jump (jump_target).
- Evaluates branch conditions from comp1/comp2/func, using the same operand and func encoding that add_pc receives.

---
 rtl/if_pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_if_pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_pc_sequencer.sv
// ---------------------------------------------------------------------------
// if_pc_sequencer
//   Fetch-stage PC sequencer. Runs a per-instruction phase counter
//   (0..DELAY_MAX) and, on the last phase of each slot, commits the next PC.
//   The next PC is chosen from the sequential address (IF_pc4, supplied by
//   add_pc), a taken conditional branch (IF_pcs + imm) or a jump
//   (jump_target). Jump has priority over branch.
//
// Ports
//   clk, nrst        : rising-edge clock, asynchronous active-low reset
//   execute          : run enable; low idles the sequencer and clears phase
//   IF_pc4           : IF_pcs+4 from add_pc, valid from phase 3
//   comp1, comp2     : branch comparison operands
//   func             : branch condition select
//   is_branch        : current instruction is a conditional branch
//   is_jump          : current instruction is an unconditional jump
//   imm              : signed branch byte offset
//   jump_target      : absolute jump address
//   IF_pcs           : current PC
//   ins_delay        : phase counter, zero-extended to 32 bits
//   commit           : one-cycle pulse on the cycle the PC updates
//   branch_taken     : last commit took a branch or jump
//   misaligned       : one-cycle pulse, with commit, when a jump/branch
//                      target had nonzero bits[1:0]
//   retired_count    : committed instruction count (wraps)
// ---------------------------------------------------------------------------
module if_pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DELAY_MAX = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        execute,
  input  logic [31:0] IF_pc4,
  input  logic [31:0] comp1,
  input  logic [31:0] comp2,
  input  logic [2:0]  func,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic [31:0] imm,
  input  logic [31:0] jump_target,
  output logic [31:0] IF_pcs,
  output logic [31:0] ins_delay,
  output logic        commit,
  output logic        branch_taken,
  output logic        misaligned,
  output logic [31:0] retired_count
);

  // Branch condition encoding shared with add_pc.
  typedef enum logic [2:0] {
    FN_EQ  = 3'b000,
    FN_NE  = 3'b001,
    FN_RS2 = 3'b010,
    FN_RS3 = 3'b011,
    FN_LT  = 3'b100,
    FN_GE  = 3'b101,
    FN_LTU = 3'b110,
    FN_GEU = 3'b111
  } func_e;

  localparam logic [3:0] LP_LAST = DELAY_MAX[3:0];

  logic [3:0]  r_phase;
  logic [31:0] r_pc;
  logic        r_commit;
  logic        r_taken;
  logic        r_misal;
  logic [31:0] r_retired;

  logic        w_last;
  logic        w_cond;
  logic        w_take;
  logic        w_check;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_misal;

  assign w_last = (r_phase == LP_LAST);

  always_comb begin
    w_cond = 1'b0;
    case (func_e'(func))
      FN_EQ:   w_cond = (comp1 == comp2);
      FN_NE:   w_cond = (comp1 != comp2);
      FN_LT:   w_cond = ($signed(comp1) <  $signed(comp2));
      FN_GE:   w_cond = ($signed(comp1) >= $signed(comp2));
      FN_LTU:  w_cond = (comp1 <  comp2);
      FN_GEU:  w_cond = (comp1 >= comp2);
      default: w_cond = 1'b0;
    endcase
  end

  // Only redirected targets are alignment-checked; IF_pc4 is trusted.
  always_comb begin
    w_target = IF_pc4;
    w_take   = 1'b0;
    w_check  = 1'b0;
    if (is_jump) begin
      w_target = jump_target;
      w_take   = 1'b1;
      w_check  = 1'b1;
    end else if (is_branch && w_cond) begin
      w_target = r_pc + imm;
      w_take   = 1'b1;
      w_check  = 1'b1;
    end
  end

  assign w_next_pc = {w_target[31:2], 2'b00};
  assign w_misal   = w_check && (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_phase   <= '0;
      r_pc      <= RESET_PC;
      r_commit  <= 1'b0;
      r_taken   <= 1'b0;
      r_misal   <= 1'b0;
      r_retired <= '0;
    end else if (!execute) begin
      r_phase  <= '0;
      r_commit <= 1'b0;
      r_misal  <= 1'b0;
    end else if (w_last) begin
      r_phase   <= '0;
      r_pc      <= w_next_pc;
      r_commit  <= 1'b1;
      r_taken   <= w_take;
      r_misal   <= w_misal;
      r_retired <= r_retired + 32'd1;
    end else begin
      r_phase  <= r_phase + 4'd1;
      r_commit <= 1'b0;
      r_misal  <= 1'b0;
    end
  end

  assign IF_pcs        = r_pc;
  assign ins_delay     = {28'd0, r_phase};
  assign commit        = r_commit;
  assign branch_taken  = r_taken;
  assign misaligned    = r_misal;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_if_pc_sequencer.sv
module tb_if_pc_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        execute;
  logic [31:0] IF_pc4;
  logic [31:0] comp1, comp2;
  logic [2:0]  func;
  logic        is_branch, is_jump;
  logic [31:0] imm, jump_target;
  logic [31:0] IF_pcs, ins_delay, retired_count;
  logic        commit, branch_taken, misaligned;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] im;
    logic [31:0] pc;
    logic        taken;
    logic        mis;
  } vec_t;
  vec_t vt[8];

  if_pc_sequencer #(.RESET_PC(32'h0000_0000), .DELAY_MAX(3)) dut (
    .clk(clk), .nrst(nrst), .execute(execute), .IF_pc4(IF_pc4),
    .comp1(comp1), .comp2(comp2), .func(func), .is_branch(is_branch),
    .is_jump(is_jump), .imm(imm), .jump_target(jump_target),
    .IF_pcs(IF_pcs), .ins_delay(ins_delay), .commit(commit),
    .branch_taken(branch_taken), .misaligned(misaligned),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // add_pc model: latches IF_pcs+4 at phase 2.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) IF_pc4 <= 32'h0;
    else if (ins_delay == 32'd2) IF_pc4 <= IF_pcs + 32'd4;
  end

  // Monitor: every commit pops one expectation.
  always @(negedge clk) begin
    if (nrst === 1'b1 && commit === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_commit: got commit with pc=%h, required no commit", IF_pcs);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (IF_pcs !== e.pc || branch_taken !== e.taken || misaligned !== e.mis) begin
          miscompares++;
          $display("FAIL commit_result: got pc=%h taken=%b mis=%b, required pc=%h taken=%b mis=%b",
                   IF_pcs, branch_taken, misaligned, e.pc, e.taken, e.mis);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic ms);
    exp_t e;
    e.pc = pc; e.taken = tk; e.mis = ms;
    sb.push_back(e);
  endtask

  initial begin
    vt[0] = '{3'b000, 32'd7,          32'd7, 32'd8,          32'h208, 1'b1, 1'b0};
    vt[1] = '{3'b001, 32'd7,          32'd7, 32'd8,          32'h20C, 1'b0, 1'b0};
    vt[2] = '{3'b101, 32'h8000_0000,  32'd1, 32'd8,          32'h210, 1'b0, 1'b0};
    vt[3] = '{3'b111, 32'h8000_0000,  32'd1, 32'd8,          32'h218, 1'b1, 1'b0};
    vt[4] = '{3'b010, 32'd1,          32'd1, 32'd8,          32'h21C, 1'b0, 1'b0};
    vt[5] = '{3'b011, 32'd0,          32'd0, 32'd8,          32'h220, 1'b0, 1'b0};
    vt[6] = '{3'b001, 32'd3,          32'd4, 32'd6,          32'h224, 1'b1, 1'b1};
    vt[7] = '{3'b100, 32'd1,          32'd2, 32'hFFFF_FFF8,  32'h21C, 1'b1, 1'b0};

    nrst = 1'b0; execute = 1'b0; comp1 = '0; comp2 = '0; func = '0;
    is_branch = 1'b0; is_jump = 1'b0; imm = '0; jump_target = '0;
    run(2);
    check("rst_pc", IF_pcs, 32'h0);
    check("rst_delay", ins_delay, 32'h0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    check("rst_taken", {31'd0, branch_taken}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    check("rst_retired", retired_count, 32'd0);

    // Sequential run.
    nrst = 1'b1;
    run(1);
    execute = 1'b1;
    push(32'h4, 1'b0, 1'b0);
    push(32'h8, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      run(1);
      check("seq_delay", ins_delay, 32'(k % 4));
      check("seq_commit", {31'd0, commit}, {31'd0, (k % 4) == 0});
    end
    check("seq_retired", retired_count, 32'd2);

    // Jump to 0x100, then signed branch backwards.
    is_jump = 1'b1; jump_target = 32'h100; push(32'h100, 1'b1, 1'b0); run(4);
    is_jump = 1'b0; is_branch = 1'b1; func = 3'b100;
    comp1 = 32'hFFFF_FFFF; comp2 = 32'd1; imm = 32'hFFFF_FFF0;
    push(32'hF0, 1'b1, 1'b0); run(4);
    is_jump = 1'b1; push(32'h100, 1'b1, 1'b0); run(4);
    is_jump = 1'b0; func = 3'b110; push(32'h104, 1'b0, 1'b0); run(4);

    // Jump beats a true branch; misaligned target.
    is_jump = 1'b1; func = 3'b000; comp1 = 32'd5; comp2 = 32'd5;
    jump_target = 32'h203; push(32'h200, 1'b1, 1'b1); run(4);
    is_jump = 1'b0;

    foreach (vt[i]) begin
      func = vt[i].fn; comp1 = vt[i].c1; comp2 = vt[i].c2; imm = vt[i].im;
      push(vt[i].pc, vt[i].taken, vt[i].mis);
      run(4);
    end

    // Idle mid-slot.
    is_branch = 1'b0;
    run(2);
    check("pre_idle_delay", ins_delay, 32'd2);
    execute = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run(1);
      check("idle_delay", ins_delay, 32'd0);
      check("idle_pc", IF_pcs, 32'h21C);
      check("idle_commit", {31'd0, commit}, 32'd0);
    end
    execute = 1'b1;
    push(32'h220, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      run(1);
      check("resume_commit", {31'd0, commit}, {31'd0, k == 4});
    end
    check("retired_total", retired_count, 32'd16);

    // Asynchronous reset at phase 3.
    run(3);
    check("pre_rst_delay", ins_delay, 32'd3);
    #2 nrst = 1'b0;
    #1;
    check("arst_pc", IF_pcs, 32'h0);
    check("arst_delay", ins_delay, 32'h0);
    check("arst_retired", retired_count, 32'h0);
    check("arst_taken", {31'd0, branch_taken}, 32'd0);
    run(1);
    check("arst_commit", {31'd0, commit}, 32'd0);
    check("arst_mis", {31'd0, misaligned}, 32'd0);
    nrst = 1'b1;
    run(1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
